// File: rtl/patram_arbiter_if.sv
// rtl/patram_arbiter_if.sv - master-side and pattern_memory-side signals of patram_arbiter
interface patram_arbiter_if #(
  parameter int NUM_PORTS = 3,
  parameter int AW        = 16
);
  logic [NUM_PORTS-1:0]      req;
  logic [NUM_PORTS*AW-1:0]   addr;
  logic [NUM_PORTS-1:0]      write;
  logic [NUM_PORTS*4-1:0]    byte_enable;
  logic [NUM_PORTS*32-1:0]   wdata;
  logic [NUM_PORTS-1:0]      ack;
  logic [31:0]               rdata;
  logic                      mem_request;
  logic [AW-1:0]             mem_addr;
  logic                      mem_write;
  logic [3:0]                mem_byte_enable;
  logic [31:0]               mem_wdata;
  logic [31:0]               mem_rdata;
  logic                      mem_ack;
  logic [2:0]                grant_id;
  logic                      err_timeout;
  logic                      err_clear;

  modport slave (
    input  req, addr, write, byte_enable, wdata, mem_rdata, mem_ack, err_clear,
    output ack, rdata, mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata,
           grant_id, err_timeout
  );

  modport master (
    output req, addr, write, byte_enable, wdata, mem_rdata, mem_ack, err_clear,
    input  ack, rdata, mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata,
           grant_id, err_timeout
  );
endinterface

// File: rtl/patram_arbiter.sv
// rtl/patram_arbiter.sv - round-robin arbiter sharing pattern_memory between NUM_PORTS masters
// Define PATRAM_ARB_PRIO_EN to give port 0 fixed priority over the rotating ports 1..NUM_PORTS-1.
module patram_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int AW        = 16,
  parameter int TIMEOUT   = 15
) (
  input logic             clock,
  input logic             reset_n,
  patram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t               state;
  logic [7:0]           wdog;
  logic [7:0]           req_ext;
  logic [2:0]           cand;
  logic [2:0]           winner;
  logic                 found;
  logic [AW-1:0]        sel_addr;
  logic                 sel_write;
  logic [3:0]           sel_be;
  logic [31:0]          sel_wdata;
  logic [NUM_PORTS-1:0] ack_onehot;
  logic                 timeout_hit;

  assign req_ext     = 8'(bus.req);
  assign timeout_hit = (wdog == 8'(TIMEOUT));

  // Search starts just after the last grant so every requester is reached within NUM_PORTS grants.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
`ifdef PATRAM_ARB_PRIO_EN
    if (req_ext[0]) begin
      found = 1'b1;
    end
`endif
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = 3'((int'(bus.grant_id) + k) % NUM_PORTS);
`ifdef PATRAM_ARB_PRIO_EN
      if (!found && cand != 3'd0 && req_ext[cand]) begin
`else
      if (!found && req_ext[cand]) begin
`endif
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    sel_addr   = '0;
    sel_write  = 1'b0;
    sel_be     = '0;
    sel_wdata  = '0;
    ack_onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (winner == 3'(i)) begin
        sel_addr  = bus.addr[i*AW +: AW];
        sel_write = bus.write[i];
        sel_be    = bus.byte_enable[i*4 +: 4];
        sel_wdata = bus.wdata[i*32 +: 32];
      end
      ack_onehot[i] = (bus.grant_id == 3'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state               <= S_IDLE;
      wdog                <= '0;
      bus.ack             <= '0;
      bus.rdata           <= '0;
      bus.mem_request     <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_write       <= 1'b0;
      bus.mem_byte_enable <= '0;
      bus.mem_wdata       <= '0;
      bus.grant_id        <= 3'(NUM_PORTS - 1);
      bus.err_timeout     <= 1'b0;
    end else begin
      // A timeout later in this block overrides the clear.
      if (bus.err_clear) begin
        bus.err_timeout <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (found) begin
            bus.mem_addr        <= sel_addr;
            bus.mem_write       <= sel_write;
            bus.mem_byte_enable <= sel_be;
            bus.mem_wdata       <= sel_wdata;
            bus.grant_id        <= winner;
            bus.mem_request     <= 1'b1;
            wdog                <= '0;
            state               <= S_WAIT;
          end
        end
        S_WAIT: begin
          bus.mem_request <= 1'b0;
          wdog            <= wdog + 8'd1;
          if (bus.mem_ack) begin
            bus.rdata <= bus.mem_rdata;
            bus.ack   <= ack_onehot;
            state     <= S_DONE;
          end else if (timeout_hit) begin
            bus.rdata       <= 32'hDEADBEEF;
            bus.ack         <= ack_onehot;
            bus.err_timeout <= 1'b1;
            state           <= S_DONE;
          end
        end
        S_DONE: begin
          bus.ack <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
